// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter that shares one data-memory port between two requesters.
// The winning address, write data and write enable are registered onto the shared
// port. The memory response comes back to the owner as a one-cycle ack. A watchdog
// aborts a transaction that the memory never acknowledges.
module mem_port_arbiter #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero TIMEOUT disables the watchdog; otherwise abort on the edge where the
  // counter has already seen TIMEOUT-1 unacknowledged BUSY edges.
  localparam logic        WD_EN   = 1'(TIMEOUT != 0);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t              state_r, state_s;
  logic [15:0]         cnt_r, cnt_s;
  logic                last_grant_r, last_grant_s;
  logic                win_s;
  logic                mem_req_s, mem_we_s, grant_s, busy_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic                ack0_s, ack1_s, err0_s, err1_s;
  logic [DATA_W-1:0]   rdata0_s, rdata1_s;

  // Next-state and next-output logic; every register holds unless a state acts on it.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    last_grant_s = last_grant_r;
    win_s        = 1'b0;
    mem_req_s    = mem_req;
    mem_we_s     = mem_we;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    grant_s      = grant;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    err0_s       = 1'b0;
    err1_s       = 1'b0;
    rdata0_s     = rdata0;
    rdata1_s     = rdata1;

    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes first.
          win_s       = (req0 && req1) ? ~last_grant_r : req1;
          grant_s     = win_s;
          mem_req_s   = 1'b1;
          mem_we_s    = win_s ? we1 : we0;
          mem_addr_s  = win_s ? addr1 : addr0;
          mem_wdata_s = win_s ? wdata1 : wdata0;
          cnt_s       = 16'd0;
          state_s     = BUSY;
        end else begin
          state_s = IDLE;
        end
      end

      BUSY: begin
        if (mem_ack) begin
          // A real ack always beats a watchdog expiry on the same edge.
          mem_req_s    = 1'b0;
          last_grant_s = grant;
          state_s      = DONE;
          if (grant) begin
            ack1_s = 1'b1;
            if (!mem_we) begin
              rdata1_s = mem_rdata;
            end else begin
              rdata1_s = rdata1;
            end
          end else begin
            ack0_s = 1'b1;
            if (!mem_we) begin
              rdata0_s = mem_rdata;
            end else begin
              rdata0_s = rdata0;
            end
          end
        end else if (WD_EN && (cnt_r == WD_LAST)) begin
          // Abort: complete towards the owner with an error and zeroed read data.
          mem_req_s    = 1'b0;
          last_grant_s = grant;
          state_s      = DONE;
          if (grant) begin
            ack1_s   = 1'b1;
            err1_s   = 1'b1;
            rdata1_s = {DATA_W{1'b0}};
          end else begin
            ack0_s   = 1'b1;
            err0_s   = 1'b1;
            rdata0_s = {DATA_W{1'b0}};
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State, watchdog and output registers; reset leaves requester 0 to win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= 16'd0;
      last_grant_r <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      grant        <= 1'b0;
      busy         <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata0       <= {DATA_W{1'b0}};
      rdata1       <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      last_grant_r <= last_grant_s;
      mem_req      <= mem_req_s;
      mem_we       <= mem_we_s;
      mem_addr     <= mem_addr_s;
      mem_wdata    <= mem_wdata_s;
      grant        <= grant_s;
      busy         <= busy_s;
      ack0         <= ack0_s;
      ack1         <= ack1_s;
      err0         <= err0_s;
      err1         <= err1_s;
      rdata0       <= rdata0_s;
      rdata1       <= rdata1_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, we0, req1, we1, mem_ack;
  logic [63:0] addr0, wdata0, addr1, wdata1, mem_rdata;
  logic        ack0, err0, ack1, err1, mem_req, mem_we, grant, busy;
  logic [63:0] rdata0, rdata1, mem_addr, mem_wdata;

  int n_chk = 0;
  int n_pass = 0;
  int ack_seen0 = 0;
  int ack_seen1 = 0;

  // Model state: who won last, and what each requester's read data should be.
  logic        m_last;
  logic [63:0] m_rdata [2];

  mem_port_arbiter #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ack_seen0 += int'(ack0);
    ack_seen1 += int'(ack1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 64'd0);
    chk({tag, "_mem_we"}, mem_we, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_grant"}, grant, 64'd0);
    chk({tag, "_busy"}, busy, 64'd0);
    chk({tag, "_ack0"}, ack0, 64'd0);
    chk({tag, "_ack1"}, ack1, 64'd0);
    chk({tag, "_err0"}, err0, 64'd0);
    chk({tag, "_err1"}, err1, 64'd0);
    chk({tag, "_rdata0"}, rdata0, 64'd0);
    chk({tag, "_rdata1"}, rdata1, 64'd0);
  endtask

  task automatic idle_cycle(input logic stray);
    req0 = 1'b0;
    req1 = 1'b0;
    mem_ack = stray;
    mem_rdata = {$urandom, $urandom};
    tick();
    chk("idle_mem_req", mem_req, 64'd0);
    chk("idle_busy", busy, 64'd0);
    chk("idle_ack", {ack1, ack0, err1, err0}, 64'd0);
    chk("idle_rdata0", rdata0, m_rdata[0]);
    chk("idle_rdata1", rdata1, m_rdata[1]);
    mem_ack = 1'b0;
  endtask

  // One full transaction: the memory answers after lat unacknowledged BUSY edges;
  // a lat that reaches the watchdog limit ends in an abort instead.
  task automatic run_txn(input logic r0, input logic r1, input logic w0, input logic w1,
                         input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input int lat, input logic [63:0] rd, output logic g);
    logic        w, wwe;
    logic [63:0] wa, wd;
    int          n_busy;
    logic        tmo;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    mem_ack = 1'b0;
    w      = (r0 && r1) ? ~m_last : r1;
    wwe    = w ? w1 : w0;
    wa     = w ? a1 : a0;
    wd     = w ? d1 : d0;
    tmo    = (lat + 1 > TMO);
    n_busy = tmo ? TMO : lat + 1;
    tick();
    g = grant;
    chk("grant", grant, 64'(w));
    chk("mem_req_rise", mem_req, 64'd1);
    chk("mem_addr", mem_addr, wa);
    chk("mem_we", mem_we, 64'(wwe));
    chk("mem_wdata", mem_wdata, wd);
    chk("busy_on", busy, 64'd1);
    for (int j = 1; j <= n_busy; j++) begin
      mem_ack   = (j == lat + 1);
      mem_rdata = (j == lat + 1) ? rd : {$urandom, $urandom};
      req0  = 1'($urandom);
      req1  = 1'($urandom);
      addr0 = {$urandom, $urandom};
      addr1 = {$urandom, $urandom};
      we0   = 1'($urandom);
      we1   = 1'($urandom);
      tick();
      if (j < n_busy) begin
        chk("hold_mem_req", mem_req, 64'd1);
        chk("hold_mem_addr", mem_addr, wa);
        chk("hold_mem_we", mem_we, 64'(wwe));
        chk("hold_mem_wdata", mem_wdata, wd);
        chk("hold_grant", grant, 64'(w));
        chk("hold_no_ack", {ack1, ack0}, 64'd0);
      end else begin
        if (tmo) begin
          m_rdata[w] = 64'd0;
        end else if (!wwe) begin
          m_rdata[w] = rd;
        end
        m_last = w;
        chk("done_mem_req", mem_req, 64'd0);
        chk("done_ack0", ack0, 64'(w == 1'b0));
        chk("done_ack1", ack1, 64'(w == 1'b1));
        chk("done_err0", err0, 64'(tmo && (w == 1'b0)));
        chk("done_err1", err1, 64'(tmo && (w == 1'b1)));
        chk("done_rdata0", rdata0, m_rdata[0]);
        chk("done_rdata1", rdata1, m_rdata[1]);
        chk("done_busy", busy, 64'd1);
      end
    end
    // DONE cycle: requests and a stray mem_ack are both ignored.
    mem_ack = 1'b1;
    req0 = 1'($urandom);
    req1 = 1'($urandom);
    tick();
    chk("post_no_ack", {ack1, ack0, err1, err0}, 64'd0);
    chk("post_mem_req", mem_req, 64'd0);
    chk("post_busy", busy, 64'd0);
    chk("post_grant", grant, 64'(w));
    chk("post_rdata0", rdata0, m_rdata[0]);
    chk("post_rdata1", rdata1, m_rdata[1]);
    mem_ack = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    logic        g;
    logic [3:0]  gseq;
    logic [1:0]  p;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; mem_ack = 1'b0;
    addr0 = 64'd0; addr1 = 64'd0; wdata0 = 64'd0; wdata1 = 64'd0; mem_rdata = 64'd0;
    m_last = 1'b1;
    m_rdata[0] = 64'd0;
    m_rdata[1] = 64'd0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    reset_n = 1'b1;

    // Read on port 0 with two wait cycles.
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'h0, 2, 64'hDEAD, g);
    chk("t1_rdata0", rdata0, 64'hDEAD);
    chk("t1_ack_counts", {32'(ack_seen0), 32'(ack_seen1)}, {32'd1, 32'd0});

    // Tie held for four transactions: grants alternate starting at 0.
    // Port 0 won the previous round, so reset the history by a fresh reset first.
    reset_n = 1'b0;
    m_last = 1'b1;
    m_rdata[0] = 64'd0;
    m_rdata[1] = 64'd0;
    #1;
    chk_all_zero("tie_reset");
    reset_n = 1'b1;
    ack_seen0 = 0;
    ack_seen1 = 0;
    gseq = 4'd0;
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b1, 1'b1, 1'b0, 1'b0, 64'h100 + 64'(k), 64'h200 + 64'(k),
              64'h0, 64'h0, k % 3, 64'hA000 + 64'(k), g);
      gseq[k] = g;
    end
    chk("tie_grant_seq", gseq, 64'b1010);
    chk("tie_ack_counts", {32'(ack_seen0), 32'(ack_seen1)}, {32'd2, 32'd2});

    // Write on port 1 leaves rdata1 untouched.
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h20, 64'h0, 64'h55, 1, 64'hBAD, g);
    chk("t3_rdata1_kept", rdata1, 64'hA003);

    // Watchdog abort on port 0, then ack arriving on the expiry edge.
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'h30, 64'h0, 64'h0, 64'h0, 20, 64'h1234, g);
    chk("t4_rdata0_zero", rdata0, 64'd0);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'h34, 64'h0, 64'h0, 64'h0, TMO - 1, 64'h4321, g);
    chk("t4_edge_rdata0", rdata0, 64'h4321);

    // Stray mem_ack while idle.
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Reset in the middle of a transaction.
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h40; req1 = 1'b0;
    tick();
    chk("t5_busy_before", mem_req, 64'd1);
    ack_seen0 = 0;
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("t5_reset");
    m_last = 1'b1;
    m_rdata[0] = 64'd0;
    m_rdata[1] = 64'd0;
    tick();
    chk("t5_no_ack0", 32'(ack_seen0), 64'd0);
    reset_n = 1'b1;
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 64'h40, 64'h0, 64'h0, 64'h0, 0, 64'h77, g);
    chk("t5_regrant", g, 64'd0);

    // Random transactions mixed with idle cycles.
    for (int t = 0; t < 40; t++) begin
      p = 2'($urandom_range(1, 3));
      run_txn(p[0], p[1], 1'($urandom), 1'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 5), {$urandom, $urandom}, g);
      if ($urandom_range(0, 3) == 0) begin
        idle_cycle(1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
